// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcode encoding and arbiter state encoding
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    // Opcode presented to the shared ALU when nobody owns it.
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arb_grant.sv
// rtl/alu_arb_grant.sv - combinational grant decision from req0/req1, state and starve_cnt
module alu_arb_grant
    import alu_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CW         = 2
) (
    input  logic            req0,
    input  logic            req1,
    input  arb_state_e      state,
    input  logic [CW-1:0]   starve_cnt,
    output logic            gnt0,
    output logic            gnt1
);

    logic starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            // Port 1 owns the ALU; port 0 waits even if port 1 goes quiet.
            ST_LOCKED: gnt1 = req1;
            default: begin
                // Port 0 has priority unless port 1 has waited STARVE_MAX cycles.
                if (req1 && (!req0 || starved)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter in front of an external shared ALU with registered result
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [3:0]  aluc0,
    input  logic [3:0]  aluc1,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_s,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    logic          gnt0_raw;
    logic          gnt1_raw;

    alu_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_grant (
        .req0       (req0),
        .req1       (req1),
        .state      (state),
        .starve_cnt (starve_cnt),
        .gnt0       (gnt0_raw),
        .gnt1       (gnt1_raw)
    );

    // No grant may be visible while reset is held.
    assign gnt0 = gnt0_raw & resetn;
    assign gnt1 = gnt1_raw & resetn;

    always_comb begin
        state_nxt  = ST_IDLE;
        starve_nxt = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_aluc   = ALU_IDLE;

        // Ownership persists only while port 1 keeps winning with lock1 held.
        if (gnt1 && lock1) begin
            state_nxt = ST_LOCKED;
        end

        if (req1 && !gnt1) begin
            starve_nxt = (starve_cnt == CW'(STARVE_MAX)) ? starve_cnt : starve_cnt + CW'(1);
        end

        if (gnt0) begin
            alu_a    = a0;
            alu_b    = b0;
            alu_aluc = aluc0;
        end else if (gnt1) begin
            alu_a    = a1;
            alu_b    = b1;
            alu_aluc = aluc1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rvalid0    <= gnt0;
            rvalid1    <= gnt1;
            if (gnt0 || gnt1) begin
                rdata <= alu_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with reference model and directed vectors
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int STARVE_MAX = 3;

    logic        clk;
    logic        resetn;
    logic        req0, req1, lock1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  aluc0, aluc1;
    logic        gnt0, gnt1;
    logic [31:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_aluc;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata;

    int checks = 0;
    int passes = 0;

    alu_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .aluc0    (aluc0),
        .aluc1    (aluc1),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_aluc (alu_aluc),
        .alu_s    (alu_s),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; undefined opcodes yield a recognisable tag value.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 32'hA5A5_0000 | {28'd0, op};
        endcase
    endfunction

    assign alu_s = alu_fn(alu_a, alu_b, alu_aluc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: grant rules stated directly, {gnt1, gnt0}.
    function automatic logic [1:0] exp_grant(input bit locked, input int starve, input logic r0,
                                             input logic r1, input logic rst_n);
        if (!rst_n) return 2'b00;
        if (locked) return {r1, 1'b0};
        if (r1 && (!r0 || starve == STARVE_MAX)) return 2'b10;
        if (r0) return 2'b01;
        return 2'b00;
    endfunction

    bit          model_ok = 1'b0;
    bit          m_locked = 1'b0;
    int          m_starve = 0;
    logic        m_rv0 = 1'b0;
    logic        m_rv1 = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  eg;
    logic [31:0] ea, eb;
    logic [3:0]  eop;

    assign eg  = exp_grant(m_locked, m_starve, req0, req1, resetn);
    assign ea  = eg[0] ? a0 : (eg[1] ? a1 : 32'd0);
    assign eb  = eg[0] ? b0 : (eg[1] ? b1 : 32'd0);
    assign eop = eg[0] ? aluc0 : (eg[1] ? aluc1 : 4'd0);

    always @(posedge clk) begin
        if (!resetn) begin
            model_ok <= 1'b1;
            m_locked <= 1'b0;
            m_starve <= 0;
            m_rv0    <= 1'b0;
            m_rv1    <= 1'b0;
            m_rdata  <= '0;
        end else begin
            m_rv0    <= eg[0];
            m_rv1    <= eg[1];
            if (eg != 2'b00) m_rdata <= alu_fn(ea, eb, eop);
            m_locked <= eg[1] && lock1;
            if (req1 && !eg[1]) m_starve <= (m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1;
            else                m_starve <= 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("cmp_gnt0",     {31'd0, gnt0},     {31'd0, eg[0]});
            chk("cmp_gnt1",     {31'd0, gnt1},     {31'd0, eg[1]});
            chk("cmp_alu_a",    alu_a,             ea);
            chk("cmp_alu_b",    alu_b,             eb);
            chk("cmp_alu_aluc", {28'd0, alu_aluc}, {28'd0, eop});
            chk("cmp_rvalid0",  {31'd0, rvalid0},  {31'd0, m_rv0});
            chk("cmp_rvalid1",  {31'd0, rvalid1},  {31'd0, m_rv1});
            chk("cmp_rdata",    rdata,             m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  pat1, pat0;
    logic [31:0] t_a  [4] = '{32'd100, 32'd7, 32'h0000_F0F0, 32'd9};
    logic [31:0] t_b  [4] = '{32'd23, 32'd9, 32'h0000_0FF0, 32'd12};
    logic [3:0]  t_op [4] = '{ALU_ADD, ALU_XOR, ALU_AND, ALU_OR};
    logic [31:0] t_r  [4] = '{32'd123, 32'd14, 32'h0000_00F0, 32'd13};

    initial begin
        resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; aluc0 = '0; aluc1 = '0;

        // Reset: grants suppressed even with requests, outputs cleared.
        tick();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        tick();
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        resetn = 1'b1; req1 = 1'b0;

        // Single port-0 ADD 5+3.
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; aluc0 = ALU_ADD;
        #1;
        chk("add_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        chk("add_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("add_rdata", rdata, 32'd8);

        // Continuous contention: port 1 wins every fourth cycle.
        req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
        a0 = 32'd1; b0 = 32'd1; aluc0 = ALU_ADD;
        a1 = 32'd20; b1 = 32'd2; aluc1 = ALU_SUB;
        for (int i = 0; i < 8; i++) begin
            #1;
            pat1[i] = gnt1;
            pat0[i] = gnt0;
            tick();
        end
        chk("starve_pat_gnt1", {24'd0, pat1}, 32'h0000_0088);
        chk("starve_pat_gnt0", {24'd0, pat0}, 32'h0000_0077);
        chk("starve_rdata", rdata, 32'd18);

        // Locked sequence: build starvation, then port 1 holds the ALU for 3 cycles.
        for (int i = 0; i < 3; i++) tick();
        lock1 = 1'b1; a1 = 32'd30; b1 = 32'd3; aluc1 = ALU_ADD;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                a1 = 32'd10; b1 = 32'd4; aluc1 = ALU_SUB;
            end
            #1;
            chk("lock_gnt0", {31'd0, gnt0}, 32'd0);
            chk("lock_gnt1", {31'd0, gnt1}, 32'd1);
            tick();
        end
        chk("lock_rdata", rdata, 32'd6);
        chk("lock_rvalid1", {31'd0, rvalid1}, 32'd1);
        lock1 = 1'b0; req1 = 1'b0; req0 = 1'b1; a0 = 32'd2; b0 = 32'd2; aluc0 = ALU_ADD;
        #1;
        chk("unlock_cycle_gnt0", {31'd0, gnt0}, 32'd0);
        tick();
        chk("unlock_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("unlock_rdata_hold", rdata, 32'd6);
        #1;
        chk("after_unlock_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        chk("after_unlock_rdata", rdata, 32'd4);

        // Back-to-back alternating ports.
        for (int i = 0; i < 4; i++) begin
            req0 = (i % 2 == 0); req1 = (i % 2 == 1);
            a0 = t_a[i]; b0 = t_b[i]; aluc0 = t_op[i];
            a1 = t_a[i]; b1 = t_b[i]; aluc1 = t_op[i];
            #1;
            chk("alt_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("alt_rvalid", {30'd0, rvalid1, rvalid0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("alt_rdata", rdata, t_r[i]);
        end

        // Undefined opcode passes straight through.
        req0 = 1'b1; req1 = 1'b0; a0 = 32'd1; b0 = 32'd2; aluc0 = 4'b1000;
        tick();
        chk("undef_rdata", rdata, 32'hA5A5_0008);

        // Idle: ALU inputs zeroed, rdata holds, no valids.
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("idle_aluc", {28'd0, alu_aluc}, 32'd0);
        chk("idle_alu_a", alu_a, 32'd0);
        tick();
        tick();
        chk("idle_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("idle_rdata_hold", rdata, 32'hA5A5_0008);

        // Reset in the middle of a locked sequence.
        req1 = 1'b1; lock1 = 1'b1; a1 = 32'd3; b1 = 32'd4; aluc1 = ALU_ADD;
        tick();
        req0 = 1'b1; a1 = 32'd50; b1 = 32'd5; a0 = 32'd11; b0 = 32'd22; aluc0 = ALU_ADD;
        #1;
        chk("midlock_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        chk("midlock_rdata", rdata, 32'd7);
        resetn = 1'b0;
        #1;
        chk("midlock_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        chk("midlock_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("midlock_rst_rdata", rdata, 32'd0);
        resetn = 1'b1; lock1 = 1'b0;
        #1;
        chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        chk("post_rst_rdata", rdata, 32'd33);
        chk("post_rst_rvalid0", {31'd0, rvalid0}, 32'd1);

        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
